// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and the transmit state type.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   FRAME_BITS = 10;
  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Processor-side handshake and serial line of the UART transmitter.
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_load;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx;
  logic                 char_sent;

  modport master (
    output tx_data, tx_load,
    input  tx_ready, tx_busy, tx, char_sent
  );

  modport slave (
    input  tx_data, tx_load,
    output tx_ready, tx_busy, tx, char_sent
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high during the last cycle of each CLKS_PER_BIT period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Count clock cycles within a bit; clear restarts the period, wrap on the last count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE_CNT;
    end
  end

  assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a character on tx_load/tx_ready and sends start, 8 data (LSB first), stop.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

  tx_state_t            state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [3:0]           bit_cnt_r, bit_cnt_s;
  logic                 tx_r, tx_s;
  logic                 ready_r, ready_s;
  logic                 busy_r;
  logic                 sent_r, sent_s;
  logic                 accept_s;
  logic                 tick_s;
  logic                 baud_clear_s;

  // The bit period is held at zero while idle so it starts fresh on every accept.
  assign baud_clear_s = (state_r == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear_s),
    .tick  (tick_s)
  );

  // State, shift register, bit counter and all outputs update together; reset forces idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_cnt_r <= 4'd0;
      tx_r      <= STOP_BIT;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      sent_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      tx_r      <= tx_s;
      ready_r   <= ready_s;
      busy_r    <= ~ready_s;
      sent_r    <= sent_s;
    end
  end

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    sent_s    = 1'b0;
    accept_s  = bus.tx_load && ready_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = START;
          shift_s   = bus.tx_data;
          bit_cnt_s = 4'd0;
        end else begin
          state_s   = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == LAST_DATA) begin
            state_s = STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_s = IDLE;
          sent_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      IDLE:    tx_s = STOP_BIT;
      START:   tx_s = START_BIT;
      DATA:    tx_s = shift_s[0];
      STOP:    tx_s = STOP_BIT;
      default: tx_s = STOP_BIT;
    endcase

    ready_s = (state_s == IDLE);
  end

  assign bus.tx        = tx_r;
  assign bus.tx_ready  = ready_r;
  assign bus.tx_busy   = busy_r;
  assign bus.char_sent = sent_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with CLKS_PER_BIT=4 and hand-written line patterns.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  uart_tx_frame_if bus ();

  uart_tx_frame #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    {31'd0, bus.tx},        32'd1);
    check({tag, "_ready"}, {31'd0, bus.tx_ready},  32'd1);
    check({tag, "_busy"},  {31'd0, bus.tx_busy},   32'd0);
    check({tag, "_sent"},  {31'd0, bus.char_sent}, 32'd0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle(tag);
    end
  endtask

  // Called at the negedge just after the accept edge; j counts cycles since accept.
  // pat is the expected line level of each of the 10 bits, in line order.
  task automatic watch_frame(input logic [0:9] pat, input string tag,
                             input int on_at, input logic [7:0] on_data,
                             input int off_at, input int abort_at);
    for (int j = 0; j <= 10 * CPB; j++) begin
      if (j == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        check_idle({tag, "_abort"});
        rst = 1'b1;
        return;
      end
      if (j < 10 * CPB) begin
        check({tag, "_tx"},    {31'd0, bus.tx},        {31'd0, pat[j / CPB]});
        check({tag, "_ready"}, {31'd0, bus.tx_ready},  32'd0);
        check({tag, "_busy"},  {31'd0, bus.tx_busy},   32'd1);
        check({tag, "_sent"},  {31'd0, bus.char_sent}, 32'd0);
      end else begin
        check({tag, "_end_tx"},    {31'd0, bus.tx},        32'd1);
        check({tag, "_end_ready"}, {31'd0, bus.tx_ready},  32'd1);
        check({tag, "_end_busy"},  {31'd0, bus.tx_busy},   32'd0);
        check({tag, "_end_sent"},  {31'd0, bus.char_sent}, 32'd1);
      end
      if (j == on_at) begin
        bus.tx_data = on_data;
        bus.tx_load = 1'b1;
      end
      if (j == off_at) begin
        bus.tx_load = 1'b0;
      end
      if (j < 10 * CPB) begin
        @(negedge clk);
      end
    end
  endtask

  // Single load pulse from idle; tx_data is scrambled right after accept.
  task automatic send(input logic [7:0] d, input logic [0:9] pat, input string tag,
                      input int on_at, input logic [7:0] on_data,
                      input int off_at, input int abort_at);
    check({tag, "_pre_ready"}, {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    bus.tx_data = ~d;
    watch_frame(pat, tag, on_at, on_data, off_at, abort_at);
  endtask

  // Directed sequence.
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = 8'h00;

    // Reset held for three edges.
    idle_cycles(3, "reset");

    // Load presented while still in reset is ignored.
    bus.tx_data = 8'h81;
    bus.tx_load = 1'b1;
    @(negedge clk);
    check_idle("load_in_reset");
    bus.tx_load = 1'b0;
    rst = 1'b1;
    idle_cycles(2, "post_reset");

    // 0xA5: 0,1,0,1,0,0,1,0,1,1.
    send(8'hA5, 10'b0101001011, "a5", -1, 8'h00, -1, -1);
    idle_cycles(1, "a5_after");

    // All-zero and all-one data.
    send(8'h00, 10'b0000000001, "x00", -1, 8'h00, -1, -1);
    idle_cycles(1, "x00_after");
    send(8'hFF, 10'b0111111111, "xff", -1, 8'h00, -1, -1);
    idle_cycles(1, "xff_after");

    // Back-to-back with tx_load held: 0x3C then 0xC3, one idle cycle between.
    bus.tx_data = 8'h3C;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_data = 8'hC3;
    watch_frame(10'b0001111001, "b2b_3c", -1, 8'h00, -1, -1);
    @(negedge clk);
    watch_frame(10'b0110000111, "b2b_c3", -1, 8'h00, 0, -1);
    idle_cycles(2, "b2b_after");

    // 0x55 pulsed during data bit 3 of a 0x0F frame is dropped.
    send(8'h0F, 10'b0111100001, "drop", 4 * CPB + 1, 8'h55, 4 * CPB + 2, -1);
    idle_cycles(3 * CPB, "drop_after");

    // Reset during data bit 5 aborts without char_sent; then a clean 0x81.
    send(8'hA5, 10'b0101001011, "abort", -1, 8'h00, -1, 6 * CPB + 1);
    idle_cycles(3, "abort_after");
    send(8'h81, 10'b0100000011, "x81", -1, 8'h00, -1, -1);
    idle_cycles(2, "x81_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
